// File: rtl/cpu_mem_responder.sv
// Purpose : CPU-side memory responder with instruction/data RAM, MMIO TX FIFO, cycle counter and a program loader.
// Latency : instructionIn and dataIn are registered, 1 cycle after the address is presented; stores land on the same edge.
// Backpr. : TX FIFO pops on txValid&&txReady; pushes to a full FIFO are dropped (sticky ovf) unless a pop happens that edge.
//
// Ports:
//   clk, nRst                      clock; synchronous active-high reset
//   instructionAddress/In          12-bit fetch address, registered 32-bit instruction (0 while cpuHold)
//   dataAddress/Out/WrEn/In        14-bit data address, store data/strobe, registered load data
//   ldStart/Valid/Last/Addr/Data   program-load port into instruction RAM; ldReady high in LOAD
//   cpuHold                        high while a program load is in progress
//   txValid/txData/txReady         host byte stream fed from the TX FIFO

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             wrOk;
  logic             rdOk;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign rdData = mem[rdPtr];

  // A push into a full FIFO still succeeds when a pop frees the slot on the same edge.
  assign rdOk = rdEn && !empty;
  assign wrOk = wrEn && (!full || rdEn);

  always_ff @(posedge clk) begin
    if (wrOk) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrOk) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (rdOk) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({wrOk, rdOk})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module cpu_mem_responder (
  input  logic        clk,
  input  logic        nRst,
  input  logic [11:0] instructionAddress,
  output logic [31:0] instructionIn,
  input  logic [13:0] dataAddress,
  input  logic [31:0] dataOut,
  input  logic        dataWrEn,
  output logic [31:0] dataIn,
  input  logic        ldStart,
  input  logic        ldValid,
  input  logic        ldLast,
  input  logic [11:0] ldAddr,
  input  logic [31:0] ldData,
  output logic        ldReady,
  output logic        cpuHold,
  output logic        txValid,
  output logic [7:0]  txData,
  input  logic        txReady
);
  localparam logic [13:0] ADDR_TXDATA = 14'h3FF0;
  localparam logic [13:0] ADDR_STATUS = 14'h3FF1;
  localparam logic [13:0] ADDR_CYCLES = 14'h3FF2;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} loadState_t;

  loadState_t  state;
  loadState_t  nextState;
  logic        drainCnt;
  logic        nextDrainCnt;

  logic [31:0] iram [0:4095];
  logic [31:0] dram [0:4095];
  logic [31:0] instrQ;
  logic [31:0] cycles;
  logic        ovf;
  logic        fifoFull;
  logic        fifoEmpty;
  logic        isRam;
  logic        statusRd;
  logic        storeEn;
  logic        txPush;
  logic        txPop;
  logic        txDrop;
  logic        iramWr;
  logic [31:0] statusWord;

  // ---------------- load FSM ----------------
  always_ff @(posedge clk) begin
    if (nRst) begin
      state    <= IDLE;
      drainCnt <= 1'b0;
    end else begin
      state    <= nextState;
      drainCnt <= nextDrainCnt;
    end
  end

  always_comb begin
    nextState    = state;
    nextDrainCnt = 1'b0;
    cpuHold      = 1'b0;
    ldReady      = 1'b0;
    case (state)
      IDLE: begin
        if (ldStart) begin
          nextState = LOAD;
        end
      end
      LOAD: begin
        cpuHold = 1'b1;
        ldReady = 1'b1;
        if (ldValid && ldLast) begin
          nextState = DRAIN;
        end
      end
      DRAIN: begin
        // Two hold cycles after the last word so the CPU restarts cleanly.
        cpuHold = 1'b1;
        if (drainCnt) begin
          nextState = IDLE;
        end else begin
          nextDrainCnt = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // ---------------- instruction RAM ----------------
  assign iramWr = !nRst && ldReady && ldValid;

  always_ff @(posedge clk) begin
    if (iramWr) begin
      iram[ldAddr] <= ldData;
    end
  end

  // Read-first: a same-edge load write is not visible to this fetch.
  always_ff @(posedge clk) begin
    if (nRst) begin
      instrQ <= '0;
    end else if (cpuHold) begin
      instrQ <= '0;
    end else begin
      instrQ <= iram[instructionAddress];
    end
  end

  // Gate so the first hold cycle also shows a NOP rather than a stale fetch.
  assign instructionIn = cpuHold ? 32'd0 : instrQ;

  // ---------------- data side ----------------
  assign isRam      = (dataAddress[13:12] == 2'b00);
  assign statusRd   = (dataAddress == ADDR_STATUS);
  assign storeEn    = dataWrEn && !cpuHold && !nRst;
  assign statusWord = {28'd0, ovf, fifoFull, fifoEmpty, cpuHold};

  always_ff @(posedge clk) begin
    if (storeEn && isRam) begin
      dram[dataAddress[11:0]] <= dataOut;
    end
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      dataIn <= '0;
    end else if (isRam) begin
      dataIn <= dram[dataAddress[11:0]];
    end else if (statusRd) begin
      dataIn <= statusWord;
    end else if (dataAddress == ADDR_CYCLES) begin
      dataIn <= cycles;
    end else begin
      dataIn <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (nRst) begin
      cycles <= '0;
    end else if (cpuHold) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // ---------------- TX path ----------------
  assign txPush  = storeEn && (dataAddress == ADDR_TXDATA);
  assign txPop   = !fifoEmpty && txReady;
  assign txDrop  = txPush && fifoFull && !txPop;
  assign txValid = !fifoEmpty;

  // Status read clears ovf, but a drop on the same edge keeps it set.
  always_ff @(posedge clk) begin
    if (nRst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= (ovf && !statusRd) || txDrop;
    end
  end

  fifo #(
    .WIDTH(8),
    .DEPTH(8)
  ) txFifo (
    .clk    (clk),
    .nRst   (nRst),
    .wrEn   (txPush),
    .wrData (dataOut[7:0]),
    .rdEn   (txReady),
    .rdData (txData),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Purpose : directed self-checking bench for cpu_mem_responder.
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next one.
// Backpr. : txReady driven directly by the scenarios.

module tb_cpu_mem_responder;
  logic        clk = 1'b0;
  logic        nRst;
  logic [11:0] instructionAddress;
  logic [31:0] instructionIn;
  logic [13:0] dataAddress;
  logic [31:0] dataOut;
  logic        dataWrEn;
  logic [31:0] dataIn;
  logic        ldStart;
  logic        ldValid;
  logic        ldLast;
  logic [11:0] ldAddr;
  logic [31:0] ldData;
  logic        ldReady;
  logic        cpuHold;
  logic        txValid;
  logic [7:0]  txData;
  logic        txReady;

  int total = 0;
  int bad   = 0;

  cpu_mem_responder dut (
    .clk                (clk),
    .nRst               (nRst),
    .instructionAddress (instructionAddress),
    .instructionIn      (instructionIn),
    .dataAddress        (dataAddress),
    .dataOut            (dataOut),
    .dataWrEn           (dataWrEn),
    .dataIn             (dataIn),
    .ldStart            (ldStart),
    .ldValid            (ldValid),
    .ldLast             (ldLast),
    .ldAddr             (ldAddr),
    .ldData             (ldData),
    .ldReady            (ldReady),
    .cpuHold            (cpuHold),
    .txValid            (txValid),
    .txData             (txData),
    .txReady            (txReady)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nRst = 1'b1; instructionAddress = '0; dataAddress = 14'h3FF2; dataOut = '0;
    dataWrEn = 1'b0; ldStart = 1'b0; ldValid = 1'b0; ldLast = 1'b0;
    ldAddr = '0; ldData = '0; txReady = 1'b0;
    tick(); tick();
    total++; if (cpuHold !== 1'b0) begin bad++; $display("FAIL rst_cpuHold got=%b want=0", cpuHold); end
    total++; if (ldReady !== 1'b0) begin bad++; $display("FAIL rst_ldReady got=%b want=0", ldReady); end
    total++; if (txValid !== 1'b0) begin bad++; $display("FAIL rst_txValid got=%b want=0", txValid); end
    total++; if (instructionIn !== 32'd0) begin bad++; $display("FAIL rst_instr got=%h want=0", instructionIn); end
    total++; if (dataIn !== 32'd0) begin bad++; $display("FAIL rst_dataIn got=%h want=0", dataIn); end
    nRst = 1'b0;
    tick();
    // first edge out of reset samples CYCLES=0, next one samples 1
    total++; if (dataIn !== 32'd0) begin bad++; $display("FAIL cycles_first got=%h want=0", dataIn); end
    tick();
    total++; if (dataIn !== 32'd1) begin bad++; $display("FAIL cycles_second got=%h want=1", dataIn); end
  endtask

  task automatic test_store_load();
    dataAddress = 14'h0005; dataOut = 32'hDEADBEEF; dataWrEn = 1'b1;
    tick();
    dataOut = 32'h12345678;             // store again while reading: read-first
    tick();
    total++; if (dataIn !== 32'hDEADBEEF) begin bad++; $display("FAIL store_load got=%h want=deadbeef", dataIn); end
    dataWrEn = 1'b0;
    tick();
    total++; if (dataIn !== 32'h12345678) begin bad++; $display("FAIL store_second got=%h want=12345678", dataIn); end
    // 0x1005 is unmapped: must not alias onto word 5
    dataAddress = 14'h1005; dataOut = 32'h0000AAAA; dataWrEn = 1'b1;
    tick();
    dataWrEn = 1'b0;
    tick();
    total++; if (dataIn !== 32'd0) begin bad++; $display("FAIL unmapped_1005 got=%h want=0", dataIn); end
    dataAddress = 14'h0005;
    tick();
    total++; if (dataIn !== 32'h12345678) begin bad++; $display("FAIL no_alias got=%h want=12345678", dataIn); end
    dataAddress = 14'h2000; dataOut = 32'h55555555; dataWrEn = 1'b1;
    tick();
    dataWrEn = 1'b0;
    tick();
    total++; if (dataIn !== 32'd0) begin bad++; $display("FAIL unmapped_2000 got=%h want=0", dataIn); end
    dataAddress = 14'h3FF0;
    tick();
    total++; if (dataIn !== 32'd0) begin bad++; $display("FAIL txdata_read got=%h want=0", dataIn); end
    // known value for the hold-store test
    dataAddress = 14'h0007; dataOut = 32'd0; dataWrEn = 1'b1;
    tick();
    dataWrEn = 1'b0;
  endtask

  task automatic test_cycles();
    logic [31:0] c1;
    dataAddress = 14'h3FF2;
    tick();
    c1 = dataIn;
    repeat (10) tick();
    total++; if (dataIn - c1 !== 32'd10) begin bad++; $display("FAIL cycles_delta got=%0d want=10", dataIn - c1); end
  endtask

  task automatic test_load();
    instructionAddress = 12'd1;
    ldStart = 1'b1;
    tick();
    ldStart = 1'b0;
    total++; if (cpuHold !== 1'b1 || ldReady !== 1'b1) begin bad++; $display("FAIL load_enter hold=%b rdy=%b want=1,1", cpuHold, ldReady); end
    total++; if (instructionIn !== 32'd0) begin bad++; $display("FAIL load_nop got=%h want=0", instructionIn); end
    // store during hold must be ignored
    dataAddress = 14'h0007; dataOut = 32'h77; dataWrEn = 1'b1;
    ldValid = 1'b1; ldAddr = 12'd0; ldData = 32'h11;
    tick();
    dataWrEn = 1'b0;
    ldAddr = 12'd1; ldData = 32'h22;
    tick();
    ldAddr = 12'd2; ldData = 32'h33; ldLast = 1'b1;
    tick();
    ldValid = 1'b0; ldLast = 1'b0;
    ldStart = 1'b1;                     // ignored outside IDLE
    total++; if (cpuHold !== 1'b1 || ldReady !== 1'b0) begin bad++; $display("FAIL drain1 hold=%b rdy=%b want=1,0", cpuHold, ldReady); end
    tick();
    ldStart = 1'b0;
    total++; if (cpuHold !== 1'b1 || ldReady !== 1'b0) begin bad++; $display("FAIL drain2 hold=%b rdy=%b want=1,0", cpuHold, ldReady); end
    tick();
    total++; if (cpuHold !== 1'b0 || ldReady !== 1'b0) begin bad++; $display("FAIL drain_exit hold=%b rdy=%b want=0,0", cpuHold, ldReady); end
    // ldValid ignored in IDLE
    ldValid = 1'b1; ldAddr = 12'd1; ldData = 32'h99;
    tick();
    ldValid = 1'b0;
    total++; if (instructionIn !== 32'h22) begin bad++; $display("FAIL fetch1 got=%h want=22", instructionIn); end
    instructionAddress = 12'd2;
    tick();
    total++; if (instructionIn !== 32'h33) begin bad++; $display("FAIL fetch2 got=%h want=33", instructionIn); end
    instructionAddress = 12'd1;
    tick();
    total++; if (instructionIn !== 32'h22) begin bad++; $display("FAIL fetch1_idle_ld got=%h want=22", instructionIn); end
    tick();
    total++; if (dataIn !== 32'd0) begin bad++; $display("FAIL hold_store got=%h want=0", dataIn); end
  endtask

  task automatic test_tx_overflow();
    txReady = 1'b0;
    dataAddress = 14'h3FF0; dataWrEn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      dataOut = 32'h41 + i;
      tick();
    end
    dataWrEn = 1'b0;
    dataAddress = 14'h3FF1;
    tick();
    // {ovf, full, empty, hold} = 1,1,0,0
    total++; if (dataIn !== {28'd0, 4'b1100}) begin bad++; $display("FAIL status_ovf got=%h want=c", dataIn); end
    tick();
    total++; if (dataIn !== {28'd0, 4'b0100}) begin bad++; $display("FAIL status_clr got=%h want=4", dataIn); end
    dataAddress = 14'h0000;
    txReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (txValid !== 1'b1 || txData !== 8'(8'h41 + i)) begin
        bad++; $display("FAIL tx_byte%0d vld=%b got=%h want=%h", i, txValid, txData, 8'(8'h41 + i));
      end
      tick();
    end
    total++; if (txValid !== 1'b0) begin bad++; $display("FAIL tx_drained vld=%b want=0", txValid); end
    txReady = 1'b0;
    dataAddress = 14'h3FF1;
    tick();
    total++; if (dataIn !== {28'd0, 4'b0010}) begin bad++; $display("FAIL status_empty got=%h want=2", dataIn); end
  endtask

  task automatic test_full_push_pop();
    txReady = 1'b0;
    dataAddress = 14'h3FF0; dataWrEn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dataOut = 32'h61 + i;
      tick();
    end
    dataOut = 32'h50; txReady = 1'b1;   // push and pop on a full FIFO
    tick();
    dataWrEn = 1'b0; txReady = 1'b0;
    dataAddress = 14'h3FF1;
    tick();
    total++; if (dataIn !== {28'd0, 4'b0100}) begin bad++; $display("FAIL pushpop_status got=%h want=4", dataIn); end
    dataAddress = 14'h0000;
    txReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] want;
      want = (i == 7) ? 8'h50 : 8'(8'h62 + i);
      total++;
      if (txValid !== 1'b1 || txData !== want) begin
        bad++; $display("FAIL pushpop_byte%0d vld=%b got=%h want=%h", i, txValid, txData, want);
      end
      tick();
    end
    total++; if (txValid !== 1'b0) begin bad++; $display("FAIL pushpop_drained vld=%b want=0", txValid); end
    txReady = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    dataAddress = 14'h3FF0; dataWrEn = 1'b1;
    dataOut = 32'h71; tick();
    dataOut = 32'h72; tick();
    dataWrEn = 1'b0; dataAddress = 14'h0000;
    total++; if (txValid !== 1'b1) begin bad++; $display("FAIL pre_rst_vld got=%b want=1", txValid); end
    ldStart = 1'b1;
    tick();
    ldStart = 1'b0;
    ldValid = 1'b1; ldAddr = 12'd5; ldData = 32'hCAFEF00D;
    tick();
    ldValid = 1'b0;
    nRst = 1'b1;
    tick();
    nRst = 1'b0;
    total++; if (cpuHold !== 1'b0 || ldReady !== 1'b0) begin bad++; $display("FAIL midload_rst hold=%b rdy=%b want=0,0", cpuHold, ldReady); end
    total++; if (txValid !== 1'b0) begin bad++; $display("FAIL midload_fifo vld=%b want=0", txValid); end
    instructionAddress = 12'd5; dataAddress = 14'h3FF1;
    tick();
    total++; if (instructionIn !== 32'hCAFEF00D) begin bad++; $display("FAIL midload_word got=%h want=cafef00d", instructionIn); end
    total++; if (dataIn !== {28'd0, 4'b0010}) begin bad++; $display("FAIL midload_status got=%h want=2", dataIn); end
    instructionAddress = 12'd1;
    tick();
    total++; if (instructionIn !== 32'h22) begin bad++; $display("FAIL ram_kept got=%h want=22", instructionIn); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_cycles();
    test_load();
    test_tx_overflow();
    test_full_push_pop();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
